// File: rtl/liga_pkg.sv
// Shared types and default constants for the liga/desliga controller.
// LIGA_ERR_BLINK_EN (optional) makes Red blink while in FAULT.
package liga_pkg;

  typedef enum logic [2:0] {
    S_OFF   = 3'd0,
    S_START = 3'd1,
    S_RUN   = 3'd2,
    S_HOLD  = 3'd3,
    S_FAULT = 3'd4
  } state_e;

  localparam int DEB_CYCLES   = 16;
  localparam int START_CYCLES = 50;
  localparam int BLINK_CYCLES = 1 << 22;

endpackage

// File: rtl/debounce.sv
// Two-flop synchroniser followed by a consecutive-mismatch debouncer.
// Output flips after DEB_CYCLES cycles of steady disagreement.
module debounce #(
  parameter int DEB_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  localparam int CW = $clog2(DEB_CYCLES + 1);

  logic [1:0]    sync_q, sync_d;
  logic          deb_q, deb_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    sync_d = {sync_q[0], din};
    deb_d  = deb_q;
    cnt_d  = '0;
    if (sync_q[1] != deb_q) begin
      if (cnt_q == CW'(DEB_CYCLES - 1))
        deb_d = sync_q[1];
      else
        cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      deb_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      sync_q <= sync_d;
      deb_q  <= deb_d;
      cnt_q  <= cnt_d;
    end
  end

  assign dout = deb_q;

endmodule

// File: rtl/liga_desliga_ctrl.sv
// On/off sequencer: debounced L/B/Pre drive OFF/START/RUN/HOLD/FAULT.
// Optional macro LIGA_ERR_BLINK_EN blinks Red while in FAULT.
module liga_desliga_ctrl #(
  parameter int DEB_CYCLES   = liga_pkg::DEB_CYCLES,
  parameter int START_CYCLES = liga_pkg::START_CYCLES,
  parameter int FCNT_W       = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              L,
  input  logic              B,
  input  logic              Pre,
  output logic              Liga,
  output logic              Gre,
  output logic              Red,
  output logic              DigOff,
  output logic              Erro,
  output logic [2:0]        State,
  output logic [FCNT_W-1:0] FaultCnt
);

  import liga_pkg::*;

  localparam int TW = $clog2(START_CYCLES + 1);

  logic ld, bd, pd;

  debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_l (
    .clk(clk), .rst(rst), .din(L), .dout(ld)
  );
  debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_b (
    .clk(clk), .rst(rst), .din(B), .dout(bd)
  );
  debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_p (
    .clk(clk), .rst(rst), .din(Pre), .dout(pd)
  );

  state_e            state_q, state_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;
  logic              fault_entry;
  logic              red_fault;

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    if (state_q == S_FAULT) begin
      if (!ld && !pd)
        state_d = S_OFF;
    end else if (!ld) begin
      state_d = S_OFF;
    end else if (pd) begin
      state_d = S_FAULT;
    end else if (bd) begin
      state_d = S_HOLD;
    end else begin
      case (state_q)
        S_OFF, S_HOLD: begin
          state_d = S_START;
          timer_d = TW'(START_CYCLES - 1);
        end
        S_START: begin
          if (timer_q == '0)
            state_d = S_RUN;
          else
            timer_d = timer_q - 1'b1;
        end
        default: state_d = state_q;
      endcase
    end
  end

  assign fault_entry = (state_d == S_FAULT) && (state_q != S_FAULT);

  always_comb begin
    fcnt_d = fcnt_q;
    if (fault_entry && (fcnt_q != '1))
      fcnt_d = fcnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_OFF;
      timer_q <= '0;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      fcnt_q  <= fcnt_d;
    end
  end

`ifdef LIGA_ERR_BLINK_EN
  // Top bit flips every BLINK_CYCLES; zero on entry gives Red=1 first.
  localparam int BW = $clog2(BLINK_CYCLES) + 1;

  logic [BW-1:0] blink_q, blink_d;

  always_comb begin
    blink_d = blink_q + 1'b1;
    if (fault_entry)
      blink_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      blink_q <= '0;
    else
      blink_q <= blink_d;
  end

  assign red_fault = ~blink_q[BW-1];
`else
  assign red_fault = 1'b1;
`endif

  always_comb begin
    Liga   = 1'b0;
    Gre    = 1'b0;
    Red    = 1'b0;
    DigOff = 1'b0;
    Erro   = 1'b0;
    case (state_q)
      S_OFF:   DigOff = 1'b1;
      S_START: Gre = 1'b1;
      S_RUN: begin
        Liga = 1'b1;
        Gre  = 1'b1;
      end
      S_HOLD:  Red = 1'b1;
      S_FAULT: begin
        Red  = red_fault;
        Erro = 1'b1;
      end
      default: DigOff = 1'b1;
    endcase
  end

  assign State    = state_q;
  assign FaultCnt = fcnt_q;

endmodule
